// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link.
//   PWM_WIDTH : default generator compare width (nominal period 2^PWM_WIDTH)
//   PWM_CNT_W : default width of the capture counters and result outputs
//   CNT_MAX   : saturation value of the capture counters at default width
//   cap_state_t : capture FSM state encoding
package pwm_pkg;

    localparam int PWM_WIDTH = 10;
    localparam int PWM_CNT_W = PWM_WIDTH + 1;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Bundle between a PWM source and the capture block.
//   pwm_in     : PWM waveform (asynchronous to the capture clock)
//   high_cnt   : high cycles of the last complete period
//   period_cnt : rise-to-rise cycles of the last complete period
//   valid      : one-cycle pulse when high_cnt/period_cnt update
//   static_lvl : input level while stuck
//   stuck      : no rising edge for 2^CNT_W-1 cycles
// Modports: master = waveform source / result consumer, slave = capture block.
interface pwm_capture_if #(
    parameter int CNT_W = pwm_pkg::PWM_CNT_W
);
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             valid;
    logic             static_lvl;
    logic             stuck;

    modport master (
        output pwm_in,
        input  high_cnt, period_cnt, valid, static_lvl, stuck
    );

    modport slave (
        input  pwm_in,
        output high_cnt, period_cnt, valid, static_lvl, stuck
    );
endinterface

// File: rtl/pwm_in_sync.sv
// Input conditioning for the PWM capture: 2-flop synchronizer, optional
// glitch filter (build macro PWM_CAPTURE_FILTER_EN) and edge detector.
//   clk, reset : system clock, asynchronous active-low reset
//   pwm_in     : raw asynchronous PWM input
//   level      : conditioned input level
//   rise, fall : single-cycle edge strobes of level
module pwm_in_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (FILT_LEN < 1) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic            filt;
    logic [FC_W-1:0] fcnt;

    // filt follows s2 only after s2 has disagreed with it for FILT_LEN
    // consecutive cycles; any return to the old level restarts the count.
    // Both edges see the same delay, so widths are preserved.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (s2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FC_W'(FILT_LEN - 1)) begin
            filt <= s2;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = s2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3 <= 1'b0;
        end else begin
            s3 <= level;
        end
    end

    assign rise = level & ~s3;
    assign fall = ~level & s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period (in clk cycles) of an incoming
// PWM waveform, reporting once per period, and flags a non-toggling input.
// Optional glitch filter in the input path: define PWM_CAPTURE_FILTER_EN.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : pwm_capture_if.slave (pwm_in in; high_cnt, period_cnt, valid,
//           static_lvl, stuck out)
//
// state | meaning
// IDLE  | after reset, waiting for the first rise; pcnt runs as a timeout
// MEAS  | measuring; each rise closes the previous period and reports it
// STUCK | no rise for CNT_MAX cycles; static_lvl tracks the input level
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int CNT_W    = WIDTH + 1,
    parameter int FILT_LEN = 3
) (
    input  logic          clk,
    input  logic          reset,
    pwm_capture_if.slave  bus
);

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic level, rise;
    // The falling edge is not needed by the counters: hcnt simply counts
    // high cycles, which stays correct for back-to-back fall/rise.
    logic fall_unused;

    pwm_in_sync #(.FILT_LEN(FILT_LEN)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (bus.pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall_unused)
    );

    cap_state_t       state;
    logic [CNT_W-1:0] hcnt, pcnt;
    logic [CNT_W-1:0] high_cnt_q, period_cnt_q;
    logic             valid_q, stuck_q, static_lvl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hcnt         <= '0;
            pcnt         <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            static_lvl_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    if (rise) begin
                        state <= MEAS;
                        hcnt  <= ONE;
                        pcnt  <= ONE;
                    end else if (pcnt == CMAX) begin
                        state        <= STUCK;
                        stuck_q      <= 1'b1;
                        static_lvl_q <= level;
                        high_cnt_q   <= level ? CMAX : '0;
                        period_cnt_q <= CMAX;
                        valid_q      <= 1'b1;
                        pcnt         <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        // The rise cycle is the first cycle of the new period.
                        high_cnt_q   <= hcnt;
                        period_cnt_q <= pcnt;
                        valid_q      <= 1'b1;
                        hcnt         <= ONE;
                        pcnt         <= ONE;
                    end else if (pcnt == CMAX) begin
                        state        <= STUCK;
                        stuck_q      <= 1'b1;
                        static_lvl_q <= level;
                        high_cnt_q   <= level ? CMAX : '0;
                        period_cnt_q <= CMAX;
                        valid_q      <= 1'b1;
                        hcnt         <= '0;
                        pcnt         <= '0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                        if (level && hcnt != CMAX) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
                STUCK: begin
                    static_lvl_q <= level;
                    if (rise) begin
                        state   <= MEAS;
                        stuck_q <= 1'b0;
                        hcnt    <= ONE;
                        pcnt    <= ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= '0;
                    pcnt  <= '0;
                end
            endcase
        end
    end

    assign bus.high_cnt   = high_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.valid      = valid_q;
    assign bus.stuck      = stuck_q;
    assign bus.static_lvl = static_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W   = PWM_CNT_W;
    localparam int SAT     = (1 << CNT_W) - 1;
    localparam int NOM_PER = 1 << PWM_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b0;

    pwm_capture_if #(.CNT_W(CNT_W)) bus();

    pwm_capture #(.WIDTH(PWM_WIDTH), .CNT_W(CNT_W), .FILT_LEN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Reference model: works on the driven waveform, one entry per expected
    // valid pulse. A period is reported when the next rise arrives; a gap of
    // more than SAT cycles since the last rise reports the stuck condition.
    typedef struct { int hi; int per; int gap; } exp_t;
    exp_t expq[$];

    bit m_cur, m_pend, m_prev_norm;
    int m_hi, m_per;

    task automatic push_exp(input int hi, input int per, input int gap);
        exp_t e;
        e.hi = hi; e.per = per; e.gap = gap;
        expq.push_back(e);
    endtask

    task automatic model_cycle(input logic lvl);
        if (lvl && !m_cur) begin
            if (m_pend) begin
                push_exp(m_hi, m_per, m_prev_norm ? m_per : 0);
                m_prev_norm = 1;
            end
            m_pend = 1; m_hi = 1; m_per = 1;
        end else if (m_pend) begin
            if (m_per == SAT) begin
                push_exp(lvl ? SAT : 0, SAT, 0);
                m_pend = 0; m_prev_norm = 0;
            end else begin
                m_per++;
                if (lvl) m_hi++;
            end
        end
        m_cur = lvl;
    endtask

    task automatic model_reset();
        m_cur = 0; m_pend = 0; m_prev_norm = 0; m_hi = 0; m_per = 0;
    endtask

    task automatic drive_raw(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pwm_in = lvl;
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.pwm_in = lvl;
            model_cycle(lvl);
        end
    endtask

    task automatic drive_pwm(input int cmp, input int n);
        for (int i = 0; i < n; i++) begin
            seg(1'b1, cmp);
            seg(1'b0, NOM_PER - cmp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got high=%0d period=%0d, expected no valid",
                         bus.high_cnt, bus.period_cnt);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("valid_high", bus.high_cnt, e.hi);
                check("valid_period", bus.period_cnt, e.per);
                if (e.gap != 0) check("valid_spacing", cyc - last_valid, e.gap);
            end
            last_valid = cyc;
        end
    end

    typedef struct { int cmp; int nper; int exp_hi; int exp_per; } vec_t;
    vec_t vecs[5];

    task automatic check_outputs(input string tag, input int hi, input int per,
                                 input int stk, input int lvl);
        check({tag, "_high"}, bus.high_cnt, hi);
        check({tag, "_period"}, bus.period_cnt, per);
        check({tag, "_stuck"}, bus.stuck, stk);
        check({tag, "_static"}, bus.static_lvl, lvl);
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        model_reset();
        vecs[0] = '{cmp: 256,  nper: 3, exp_hi: 256,  exp_per: 1024};
        vecs[1] = '{cmp: 760,  nper: 2, exp_hi: 760,  exp_per: 1024};
        vecs[2] = '{cmp: 100,  nper: 2, exp_hi: 100,  exp_per: 1024};
        vecs[3] = '{cmp: 4,    nper: 2, exp_hi: 4,    exp_per: 1024};
        vecs[4] = '{cmp: 1020, nper: 2, exp_hi: 1020, exp_per: 1024};

        repeat (3) @(negedge clk);
        check_outputs("reset", 0, 0, 0, 0);
        check("reset_valid", bus.valid, 0);
        reset = 1'b1;

        // Table-driven duty cycles
        for (int k = 0; k < 5; k++) begin
            drive_pwm(vecs[k].cmp, vecs[k].nper);
            check($sformatf("tbl%0d_high", k), bus.high_cnt, vecs[k].exp_hi);
            check($sformatf("tbl%0d_period", k), bus.period_cnt, vecs[k].exp_per);
        end

        // 100% duty: stuck high, then resume
        drive_pwm(256, 2);
        seg(1'b1, 3000);
        check_outputs("stuck_hi", SAT, SAT, 1, 1);
        seg(1'b0, 500);
        check("stuck_hi_lowphase_stuck", bus.stuck, 1);
        check("stuck_hi_lowphase_static", bus.static_lvl, 0);
        seg(1'b1, 256);
        check("resume_hi_stuck", bus.stuck, 0);
        seg(1'b0, 768);
        drive_pwm(256, 2);
        check("resume_hi_high", bus.high_cnt, 256);

        // 0% duty: stuck low, then resume
        seg(1'b0, 3000);
        check_outputs("stuck_lo", 0, SAT, 1, 0);
        drive_pwm(512, 3);
        check("resume_lo_stuck", bus.stuck, 0);
        check("resume_lo_high", bus.high_cnt, 512);

        // Reset in the middle of a period
        drive_pwm(100, 2);
        seg(1'b1, 100);
        seg(1'b0, 40);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs("midreset", 0, 0, 0, 0);
        check("midreset_valid", bus.valid, 0);
        model_reset();
        drive_raw(1'b0, 4);
        reset = 1'b1;
        seg(1'b0, 800);
        seg(1'b1, 100);
        seg(1'b0, 924);
        check("after_reset_one_rise_period", bus.period_cnt, 0);
        check("after_reset_one_rise_high", bus.high_cnt, 0);
        drive_pwm(100, 2);
        check("after_reset_high", bus.high_cnt, 100);
        check("after_reset_period", bus.period_cnt, 1024);

        // One-cycle glitch in the low phase
        drive_pwm(256, 2);
        seg(1'b1, 256);
        seg(1'b0, 400);
`ifdef PWM_CAPTURE_FILTER_EN
        drive_raw(1'b1, 1);
        model_cycle(1'b0);
`else
        seg(1'b1, 1);
`endif
        seg(1'b0, 367);
        drive_pwm(256, 2);
        check("glitch_high", bus.high_cnt, 256);
        check("glitch_period", bus.period_cnt, 1024);

        // Random waveforms against the model
        for (int i = 0; i < 40; i++) begin
            seg(1'b1, $urandom_range(300, 4));
            seg(1'b0, $urandom_range(300, 4));
        end
        drive_pwm(256, 1);

        repeat (20) @(negedge clk);
        check("missing_valids", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
